// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: operation encodings and small helpers shared by the ALU
// core, its compare unit and the decode/execute stage that drives i_op.
package cpu_alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned SHAMT_W = 5;

  // Operation encodings. Codes 15 and 20-31 are reserved and yield zero.
  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_EQ     = 5'd8,
    OP_NE     = 5'd9,
    OP_LT     = 5'd10,
    OP_GE     = 5'd11,
    OP_LTU    = 5'd12,
    OP_GEU    = 5'd13,
    OP_PASS2  = 5'd14,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19
  } alu_op_e;

  // True for the six compare/branch operations handled by cpu_alu_compare.
  function automatic logic is_cmp_op(input logic [OP_W-1:0] op);
    return (op >= 5'd8) && (op <= 5'd13);
  endfunction

endpackage

// File: rtl/cpu_alu_if.sv
// cpu_alu_if: operand/result bundle between the decode/execute stage
// (master) and the ALU (slave).
interface cpu_alu_if;
  import cpu_alu_pkg::*;

  logic            stall;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] result;

  modport master (
    output stall,
    output op,
    output op1,
    output op2,
    input  result
  );

  modport slave (
    input  stall,
    input  op,
    input  op1,
    input  op2,
    output result
  );

endinterface

// File: rtl/cpu_alu_compare.sv
// cpu_alu_compare: purely combinational equality, signed and unsigned
// compares for branch resolution. Non-compare ops report false.
module cpu_alu_compare
  import cpu_alu_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            cmp_true_o
);

  logic eq_s;
  logic lt_s;
  logic ltu_s;

  assign eq_s  = (op1_i == op2_i);
  assign lt_s  = ($signed(op1_i) < $signed(op2_i));
  assign ltu_s = (op1_i < op2_i);

  // Select the requested relation; GE/GEU are the complements of LT/LTU.
  always_comb begin
    cmp_true_o = 1'b0;
    case (op_i)
      OP_EQ:   cmp_true_o = eq_s;
      OP_NE:   cmp_true_o = ~eq_s;
      OP_LT:   cmp_true_o = lt_s;
      OP_GE:   cmp_true_o = ~lt_s;
      OP_LTU:  cmp_true_o = ltu_s;
      OP_GEU:  cmp_true_o = ~ltu_s;
      default: cmp_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_alu_core.sv
// cpu_alu_core: single-cycle integer ALU with a registered result.
// Optional RV32M multiply (ops 16-19) is built only when the macro
// CPU_ALU_MUL_EN is defined; otherwise those ops return zero and no
// multiplier is generated.
module cpu_alu_core
  import cpu_alu_pkg::*;
(
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  output logic [XLEN-1:0] o_result
);

  logic [XLEN-1:0]    result_q;
  logic [XLEN-1:0]    result_d;
  logic [SHAMT_W-1:0] shamt_s;
  logic               cmp_true_s;
  logic [XLEN-1:0]    mul_res_s;

  // Only the low five bits of op2 form the shift amount.
  assign shamt_s = i_op2[SHAMT_W-1:0];

  cpu_alu_compare u_compare (
    .op_i       (i_op),
    .op1_i      (i_op1),
    .op2_i      (i_op2),
    .cmp_true_o (cmp_true_s)
  );

`ifdef CPU_ALU_MUL_EN
  logic [63:0] mul_a_s;
  logic [63:0] mul_b_s;
  logic [63:0] mul_prod_s;

  // Extend operands to 64 bits (sign or zero per op) so one unsigned
  // 64-bit product serves MUL, MULH, MULHSU and MULHU.
  always_comb begin
    mul_a_s = {32'h0, i_op1};
    mul_b_s = {32'h0, i_op2};
    if ((i_op == OP_MULH) || (i_op == OP_MULHSU)) begin
      mul_a_s = {{32{i_op1[31]}}, i_op1};
    end else begin
      mul_a_s = {32'h0, i_op1};
    end
    if (i_op == OP_MULH) begin
      mul_b_s = {{32{i_op2[31]}}, i_op2};
    end else begin
      mul_b_s = {32'h0, i_op2};
    end
  end

  assign mul_prod_s = mul_a_s * mul_b_s;

  // MUL takes the low word; the high-word variants take bits 63:32.
  always_comb begin
    mul_res_s = 32'h0;
    case (i_op)
      OP_MUL:    mul_res_s = mul_prod_s[31:0];
      OP_MULH:   mul_res_s = mul_prod_s[63:32];
      OP_MULHSU: mul_res_s = mul_prod_s[63:32];
      OP_MULHU:  mul_res_s = mul_prod_s[63:32];
      default:   mul_res_s = 32'h0;
    endcase
  end
`else
  // Multiply disabled: ops 16-19 read as zero.
  assign mul_res_s = 32'h0;
`endif

  // Next-result decode; reserved codes and unknown ops produce zero.
  always_comb begin
    result_d = 32'h0;
    case (i_op)
      OP_ADD:    result_d = i_op1 + i_op2;
      OP_SUB:    result_d = i_op1 - i_op2;
      OP_AND:    result_d = i_op1 & i_op2;
      OP_OR:     result_d = i_op1 | i_op2;
      OP_XOR:    result_d = i_op1 ^ i_op2;
      OP_SLL:    result_d = i_op1 << shamt_s;
      OP_SRL:    result_d = i_op1 >> shamt_s;
      OP_SRA:    result_d = $unsigned($signed(i_op1) >>> shamt_s);
      OP_EQ,
      OP_NE,
      OP_LT,
      OP_GE,
      OP_LTU,
      OP_GEU:    result_d = {31'h0, cmp_true_s};
      OP_PASS2:  result_d = i_op2;
      OP_MUL,
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  result_d = mul_res_s;
      default:   result_d = 32'h0;
    endcase
  end

  // Result register: reset beats stall, stall holds the previous value.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      result_q <= 32'h0;
    end else if (!i_stall) begin
      result_q <= result_d;
    end else begin
      result_q <= result_q;
    end
  end

  assign o_result = result_q;

endmodule

// File: tb/tb_cpu_alu_core.sv
// tb_cpu_alu_core: directed vectors with hand-computed expected results.
// Build with +define+CPU_ALU_MUL_EN to exercise the multiply ops.
module tb_cpu_alu_core;
  import cpu_alu_pkg::*;

  logic i_clock;
  logic i_reset;
  int   n_tests;
  int   n_failed;

  cpu_alu_if alu_bus ();

  cpu_alu_core dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_stall  (alu_bus.stall),
    .i_op     (alu_bus.op),
    .i_op1    (alu_bus.op1),
    .i_op2    (alu_bus.op2),
    .o_result (alu_bus.result)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drive one operation, let one edge pass, then sample 1 time unit later.
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    alu_bus.op  = op;
    alu_bus.op1 = a;
    alu_bus.op2 = b;
    @(posedge i_clock);
    #1;
    check_eq(tag, alu_bus.result, exp);
  endtask

  initial begin
    n_tests       = 0;
    n_failed      = 0;
    i_reset       = 1'b0;
    alu_bus.stall = 1'b0;
    alu_bus.op    = OP_ADD;
    alu_bus.op1   = 32'h11111111;
    alu_bus.op2   = 32'h22222222;

    // Reset with a live ADD on the inputs must still clear the result.
    repeat (2) @(posedge i_clock);
    #1;
    check_eq("reset_state", alu_bus.result, 32'h0);

    // First edge after reset release computes normally.
    i_reset = 1'b1;
    run_op("first_after_reset", OP_ADD, 32'd3, 32'd4, 32'd7);

    run_op("add_wrap",   OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0);
    run_op("sub_wrap",   OP_SUB, 32'h0, 32'h1, 32'hFFFFFFFF);
    run_op("sub_basic",  OP_SUB, 32'd100, 32'd58, 32'd42);
    run_op("and",        OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    run_op("or",         OP_OR,  32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11);
    run_op("xor",        OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);

    run_op("sra_msb",    OP_SRA, 32'h80000000, 32'h21, 32'hC0000000);
    run_op("srl_msb",    OP_SRL, 32'h80000000, 32'h21, 32'h40000000);
    run_op("sll_msb",    OP_SLL, 32'h80000000, 32'h21, 32'h0);
    run_op("sll_by4",    OP_SLL, 32'h0000_00F1, 32'h4, 32'h0000_0F10);
    run_op("sra_by31",   OP_SRA, 32'h8000_0000, 32'h1F, 32'hFFFF_FFFF);
    run_op("srl_shamt0", OP_SRL, 32'h8765_4321, 32'h20, 32'h8765_4321);

    run_op("lt_neg",     OP_LT,  32'hFFFFFFFF, 32'h1, 32'h1);
    run_op("ltu_big",    OP_LTU, 32'hFFFFFFFF, 32'h1, 32'h0);
    run_op("ge_neg",     OP_GE,  32'hFFFFFFFF, 32'h1, 32'h0);
    run_op("geu_big",    OP_GEU, 32'hFFFFFFFF, 32'h1, 32'h1);
    run_op("eq_true",    OP_EQ,  32'h5, 32'h5, 32'h1);
    run_op("ne_false",   OP_NE,  32'h5, 32'h5, 32'h0);
    run_op("eq_false",   OP_EQ,  32'h5, 32'h6, 32'h0);
    run_op("ge_equal",   OP_GE,  32'h7, 32'h7, 32'h1);

    run_op("pass2",      OP_PASS2, 32'hDEADBEEF, 32'h12345000, 32'h12345000);
    run_op("rsvd_15",    5'd15, 32'hDEADBEEF, 32'h12345678, 32'h0);
    run_op("rsvd_31",    5'd31, 32'hCAFEF00D, 32'h0BADF00D, 32'h0);

`ifdef CPU_ALU_MUL_EN
    run_op("mul",        OP_MUL,    32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE);
    run_op("mulhu",      OP_MULHU,  32'hFFFFFFFF, 32'h2, 32'h1);
    run_op("mulh",       OP_MULH,   32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
    run_op("mulhsu",     OP_MULHSU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF);
    run_op("mulh_pos",   OP_MULH,   32'h4000_0000, 32'h8, 32'h2);
`else
    run_op("mul_off",    OP_MUL,    32'hFFFFFFFF, 32'h2, 32'h0);
    run_op("mulhu_off",  OP_MULHU,  32'hFFFFFFFF, 32'h2, 32'h0);
    run_op("mulh_off",   OP_MULH,   32'hFFFFFFFF, 32'h2, 32'h0);
    run_op("mulhsu_off", OP_MULHSU, 32'hFFFFFFFF, 32'h2, 32'h0);
`endif

    // Stall holds the result; reset while stalled still clears it.
    run_op("stall_setup", OP_ADD, 32'd3, 32'd4, 32'd7);
    alu_bus.stall = 1'b1;
    run_op("stall_hold1", OP_SUB, 32'd3, 32'd4, 32'd7);
    run_op("stall_hold2", OP_XOR, 32'hFFFF, 32'h1, 32'd7);
    i_reset = 1'b0;
    run_op("reset_in_stall", OP_SUB, 32'd3, 32'd4, 32'h0);
    i_reset       = 1'b1;
    alu_bus.stall = 1'b0;
    run_op("resume", OP_SUB, 32'd3, 32'd4, 32'hFFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
